// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the fetch-stage sequencer.
//   i1 / i32       : common scalar and word types used on every fetch port
//   fetch_state_t  : sequencer states
//   RESET_PC_DEFAULT, EXC_VEC : architectural fetch addresses
//   pc_inc()       : sequential-fetch increment (wraps modulo 2^32)
// -----------------------------------------------------------------------------
package fetch_pkg;

    typedef logic        i1;
    typedef logic [31:0] i32;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        DATA = 3'd2,
        HOLD = 3'd3,
        DROP = 3'd4
    } fetch_state_t;

    localparam i32 RESET_PC_DEFAULT = 32'hbfc0_0000;
    localparam i32 EXC_VEC          = 32'hbfc0_0380;

    // Next sequential instruction address; the carry out is dropped on purpose.
    function automatic i32 pc_inc(input i32 pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_redirect_sel.sv
// -----------------------------------------------------------------------------
// fetch_redirect_sel
// Combinational priority select between exception and branch redirects.
//   i_exc_valid / i_exc_pc : exception redirect (highest priority)
//   i_br_valid  / i_br_pc  : branch-mispredict redirect
//   o_redirect             : any redirect taken this cycle
//   o_target               : address to fetch from after the redirect
// -----------------------------------------------------------------------------
module fetch_redirect_sel
    import fetch_pkg::*;
(
    input  i1  i_exc_valid,
    input  i32 i_exc_pc,
    input  i1  i_br_valid,
    input  i32 i_br_pc,
    output i1  o_redirect,
    output i32 o_target
);

    // Exception beats branch when both are asserted together.
    always_comb begin
        o_redirect = i_exc_valid | i_br_valid;
        if (i_exc_valid) begin
            o_target = i_exc_pc;
        end else begin
            o_target = i_br_pc;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
// Fetch-stage sequencer: owns the fetch PC, runs a one-outstanding-request
// instruction-bus handshake, absorbs redirects (also while a request is in
// flight) and hands fetched instructions to decode with valid/ready.
//   clk, reset                    : clock, synchronous active-high reset
//   exc_valid/exc_pc, br_valid/br_pc : redirect requests
//   ireq_valid/ireq_addr          : bus request
//   iresp_addr_ok/data_ok/data    : bus acceptance and response
//   f_valid/f_instr/f_instr_pc    : instruction offered to decode
//   d_ready                       : decode takes f_instr this cycle
//   F_pc/F_stall                  : load value and hold for the fetch register
// -----------------------------------------------------------------------------
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter i32 RESET_PC = RESET_PC_DEFAULT
) (
    input  i1  clk,
    input  i1  reset,
    input  i1  exc_valid,
    input  i32 exc_pc,
    input  i1  br_valid,
    input  i32 br_pc,
    output i1  ireq_valid,
    output i32 ireq_addr,
    input  i1  iresp_addr_ok,
    input  i1  iresp_data_ok,
    input  i32 iresp_data,
    output i1  f_valid,
    output i32 f_instr,
    output i32 f_instr_pc,
    input  i1  d_ready,
    output i32 F_pc,
    output i1  F_stall
);

    fetch_state_t r_state;
    i32           r_pc;
    i32           r_instr_q;
    i32           r_instr_pc_q;

    fetch_state_t w_state_nxt;
    i32           w_pc_nxt;
    i1            w_capture;
    i1            w_redirect;
    i32           w_target;
    i1            w_handoff;

    fetch_redirect_sel u_redirect_sel (
        .i_exc_valid (exc_valid),
        .i_exc_pc    (exc_pc),
        .i_br_valid  (br_valid),
        .i_br_pc     (br_pc),
        .o_redirect  (w_redirect),
        .o_target    (w_target)
    );

    // Next-state and next-PC selection.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_capture   = 1'b0;
        case (r_state)
            IDLE: begin
                w_state_nxt = ADDR;
                if (w_redirect) begin
                    w_pc_nxt = w_target;
                end else begin
                    w_pc_nxt = r_pc;
                end
            end
            ADDR: begin
                if (w_redirect) begin
                    w_pc_nxt = w_target;
                    // An accepted request must still have its response drained.
                    if (iresp_addr_ok) begin
                        w_state_nxt = DROP;
                    end else begin
                        w_state_nxt = ADDR;
                    end
                end else if (iresp_addr_ok) begin
                    w_state_nxt = DATA;
                end else begin
                    w_state_nxt = ADDR;
                end
            end
            DATA: begin
                if (iresp_data_ok && !w_redirect) begin
                    w_capture   = 1'b1;
                    w_pc_nxt    = pc_inc(r_pc);
                    w_state_nxt = HOLD;
                end else if (w_redirect && iresp_data_ok) begin
                    // Response arrives with the redirect: nothing left to drain.
                    w_pc_nxt    = w_target;
                    w_state_nxt = ADDR;
                end else if (w_redirect) begin
                    w_pc_nxt    = w_target;
                    w_state_nxt = DROP;
                end else begin
                    w_state_nxt = DATA;
                end
            end
            DROP: begin
                if (w_redirect) begin
                    w_pc_nxt = w_target;
                end else begin
                    w_pc_nxt = r_pc;
                end
                if (iresp_data_ok) begin
                    w_state_nxt = ADDR;
                end else begin
                    w_state_nxt = DROP;
                end
            end
            HOLD: begin
                if (w_redirect) begin
                    w_pc_nxt    = w_target;
                    w_state_nxt = ADDR;
                end else if (d_ready) begin
                    w_state_nxt = ADDR;
                end else begin
                    w_state_nxt = HOLD;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_pc_nxt    = r_pc;
            end
        endcase
    end

    // Bus, decode and fetch-register outputs decoded from the current state.
    always_comb begin
        ireq_valid = 1'b0;
        ireq_addr  = 32'h0000_0000;
        if (r_state == ADDR) begin
            ireq_valid = 1'b1;
            ireq_addr  = r_pc;
        end else begin
            ireq_valid = 1'b0;
            ireq_addr  = 32'h0000_0000;
        end
        // A redirect retracts the offer so decode never takes a squashed word.
        w_handoff  = (r_state == HOLD) & d_ready & ~w_redirect;
        f_valid    = (r_state == HOLD) & ~w_redirect;
        f_instr    = r_instr_q;
        f_instr_pc = r_instr_pc_q;
        F_pc       = r_instr_pc_q;
        F_stall    = ~w_handoff;
    end

    // State, PC and held-instruction registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_pc         <= RESET_PC;
            r_instr_q    <= 32'h0000_0000;
            r_instr_pc_q <= 32'h0000_0000;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            if (w_capture) begin
                r_instr_q    <= iresp_data;
                r_instr_pc_q <= r_pc;
            end else begin
                r_instr_q    <= r_instr_q;
                r_instr_pc_q <= r_instr_pc_q;
            end
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_ctrl
// Directed scenarios followed by randomized traffic for fetch_ctrl. A
// transaction-level model (pending issue / in-flight / discard / held flags)
// predicts every output each cycle; a small bus model answers requests with a
// per-address instruction word.
// -----------------------------------------------------------------------------
module tb_fetch_ctrl;

    localparam logic [31:0] RST_PC = 32'hbfc0_0000;

    logic        clk = 1'b0;
    logic        reset, exc_valid, br_valid, iresp_addr_ok, iresp_data_ok, d_ready;
    logic [31:0] exc_pc, br_pc, iresp_data;
    logic        ireq_valid, f_valid, F_stall;
    logic [31:0] ireq_addr, f_instr, f_instr_pc, F_pc;

    int checks   = 0;
    int failures = 0;

    // reference model state
    bit          m_fresh, m_issue, m_wait, m_discard, m_hold;
    logic [31:0] m_pc, m_instr, m_instr_pc;
    // bus model state
    bit          bus_busy;
    logic [31:0] bus_addr;
    // outputs sampled in the most recent cycle
    logic        s_ireq_valid, s_f_valid, s_F_stall;
    logic [31:0] s_ireq_addr, s_f_instr, s_f_instr_pc, s_F_pc;

    always #5 clk = ~clk;

    fetch_ctrl #(.RESET_PC(RST_PC)) dut (
        .clk           (clk),
        .reset         (reset),
        .exc_valid     (exc_valid),
        .exc_pc        (exc_pc),
        .br_valid      (br_valid),
        .br_pc         (br_pc),
        .ireq_valid    (ireq_valid),
        .ireq_addr     (ireq_addr),
        .iresp_addr_ok (iresp_addr_ok),
        .iresp_data_ok (iresp_data_ok),
        .iresp_data    (iresp_data),
        .f_valid       (f_valid),
        .f_instr       (f_instr),
        .f_instr_pc    (f_instr_pc),
        .d_ready       (d_ready),
        .F_pc          (F_pc),
        .F_stall       (F_stall)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9bdf;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_fresh    = 1'b1;
        m_issue    = 1'b0;
        m_wait     = 1'b0;
        m_discard  = 1'b0;
        m_hold     = 1'b0;
        m_pc       = RST_PC;
        m_instr    = 32'h0;
        m_instr_pc = 32'h0;
        bus_busy   = 1'b0;
        bus_addr   = 32'h0;
    endtask

    // One clock cycle: entered and left at posedge+1.
    task automatic cyc(input bit rst, input bit exc, input bit br, input bit aok,
                       input bit dok, input bit drdy,
                       input logic [31:0] epc, input logic [31:0] bpc);
        bit          redir;
        logic [31:0] tgt;
        reset         = rst;
        exc_valid     = exc;
        br_valid      = br;
        exc_pc        = epc;
        br_pc         = bpc;
        iresp_addr_ok = aok;
        iresp_data_ok = dok;
        d_ready       = drdy;
        iresp_data    = (dok && bus_busy) ? mem_word(bus_addr) : $urandom;
        #1;
        s_ireq_valid = ireq_valid;   s_ireq_addr  = ireq_addr;
        s_f_valid    = f_valid;      s_f_instr    = f_instr;
        s_f_instr_pc = f_instr_pc;   s_F_pc       = F_pc;
        s_F_stall    = F_stall;
        redir = exc | br;
        tgt   = exc ? epc : bpc;
        chk("ireq_valid", {31'd0, ireq_valid}, {31'd0, m_issue});
        chk("ireq_addr", ireq_addr, m_issue ? m_pc : 32'h0);
        chk("f_valid", {31'd0, f_valid}, {31'd0, m_hold & ~redir});
        chk("f_instr", f_instr, m_instr);
        chk("f_instr_pc", f_instr_pc, m_instr_pc);
        chk("F_pc", F_pc, m_instr_pc);
        chk("F_stall", {31'd0, F_stall}, {31'd0, ~(m_hold & drdy & ~redir)});
        if (f_valid) chk("f_instr_mem", f_instr, mem_word(f_instr_pc));
        // bus bookkeeping
        if (rst) begin
            bus_busy = 1'b0;
        end else begin
            if (dok) bus_busy = 1'b0;
            if (ireq_valid && aok) begin
                bus_busy = 1'b1;
                bus_addr = ireq_addr;
            end
        end
        // transaction-level model update
        if (rst) begin
            model_reset();
        end else if (m_fresh) begin
            m_fresh = 1'b0;
            m_issue = 1'b1;
            if (redir) m_pc = tgt;
        end else if (m_issue) begin
            if (redir) m_pc = tgt;
            if (aok) begin
                m_issue   = 1'b0;
                m_wait    = 1'b1;
                m_discard = redir;
            end
        end else if (m_wait) begin
            if (dok) begin
                m_wait = 1'b0;
                if (!m_discard && !redir) begin
                    m_instr    = iresp_data;
                    m_instr_pc = m_pc;
                    m_pc       = m_pc + 32'd4;
                    m_hold     = 1'b1;
                end else begin
                    m_issue = 1'b1;
                    if (redir) m_pc = tgt;
                end
                m_discard = 1'b0;
            end else if (redir) begin
                m_pc      = tgt;
                m_discard = 1'b1;
            end
        end else if (m_hold) begin
            if (redir) begin
                m_pc    = tgt;
                m_hold  = 1'b0;
                m_issue = 1'b1;
            end else if (drdy) begin
                m_hold  = 1'b0;
                m_issue = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Randomized cycle: a bus that may stall, plus occasional protocol noise.
    task automatic rcyc();
        bit          rst, exc, br, aok, dok, drdy;
        logic [31:0] epc, bpc;
        rst  = ($urandom % 256) == 0;
        exc  = ($urandom % 24) == 0;
        br   = ($urandom % 10) == 0;
        aok  = ireq_valid ? (($urandom % 3) != 0) : (($urandom % 16) == 0);
        dok  = bus_busy ? (($urandom % 3) == 0) : (($urandom % 16) == 0);
        drdy = ($urandom % 2) == 0;
        epc  = (($urandom % 2) == 0) ? 32'hbfc0_0380 : ($urandom & 32'hffff_fffc);
        bpc  = (($urandom % 4) == 0) ? 32'hffff_fffc : ($urandom & 32'hffff_fffc);
        cyc(rst, exc, br, aok, dok, drdy, epc, bpc);
    endtask

    initial begin
        reset = 1'b1; exc_valid = 1'b0; br_valid = 1'b0; exc_pc = 32'h0; br_pc = 32'h0;
        iresp_addr_ok = 1'b0; iresp_data_ok = 1'b0; iresp_data = 32'h0; d_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        // ideal bus, decode always ready: 3 cycles per instruction
        for (int c = 0; c < 10; c++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0, 32'h0);
            if (c == 0) begin
                chk("rst_ireq_valid", {31'd0, s_ireq_valid}, 32'd0);
                chk("rst_f_valid", {31'd0, s_f_valid}, 32'd0);
                chk("rst_F_stall", {31'd0, s_F_stall}, 32'd1);
                chk("rst_f_instr", s_f_instr, 32'h0);
            end else if (c % 3 == 1) begin
                chk("ideal_ireq_valid", {31'd0, s_ireq_valid}, 32'd1);
                chk("ideal_ireq_addr", s_ireq_addr, RST_PC + 32'(4 * (c / 3)));
            end else if (c % 3 == 0) begin
                chk("ideal_f_valid", {31'd0, s_f_valid}, 32'd1);
                chk("ideal_f_pc", s_f_instr_pc, RST_PC + 32'(4 * (c / 3 - 1)));
            end else begin
                chk("ideal_f_idle", {31'd0, s_f_valid}, 32'd0);
            end
        end

        // addr_ok withheld 3 cycles after a fresh reset
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b0, 1'b0, (i == 3), 1'b0, 1'b0, 32'h0, 32'h0);
            chk("wait_ireq_valid", {31'd0, s_ireq_valid}, 32'd1);
            chk("wait_ireq_addr", s_ireq_addr, RST_PC);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        chk("wait_data_noreq", {31'd0, s_ireq_valid}, 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
        chk("wait_hold_pc", s_f_instr_pc, RST_PC);

        // branch redirect in DATA, response 2 cycles later is dropped
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h8000_1000);
        chk("drop_f_valid0", {31'd0, s_f_valid}, 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
        chk("drop_f_valid1", {31'd0, s_f_valid}, 32'd0);
        chk("drop_noreq", {31'd0, s_ireq_valid}, 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0);
        chk("drop_f_valid2", {31'd0, s_f_valid}, 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("br_ireq_valid", {31'd0, s_ireq_valid}, 32'd1);
        chk("br_ireq_addr", s_ireq_addr, 32'h8000_1000);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);

        // exception and branch together in HOLD: exception wins
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'hbfc0_0380, 32'h1234_5678);
        chk("tie_f_valid", {31'd0, s_f_valid}, 32'd0);
        chk("tie_F_stall", {31'd0, s_F_stall}, 32'd1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("tie_ireq_addr", s_ireq_addr, 32'hbfc0_0380);

        // decode back-pressure for 5 cycles in HOLD
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            chk("bp_f_valid", {31'd0, s_f_valid}, 32'd1);
            chk("bp_f_instr", s_f_instr, mem_word(32'hbfc0_0380));
            chk("bp_F_stall", {31'd0, s_F_stall}, 32'd1);
            chk("bp_noreq", {31'd0, s_ireq_valid}, 32'd0);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
        chk("bp_release_stall", {31'd0, s_F_stall}, 32'd0);
        chk("bp_release_F_pc", s_F_pc, 32'hbfc0_0380);

        // reset while the request is in DATA
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("seq_ireq_addr", s_ireq_addr, 32'hbfc0_0384);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("midrst_noreq", {31'd0, s_ireq_valid}, 32'd0);
        chk("midrst_f_valid", {31'd0, s_f_valid}, 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("midrst_refetch", s_ireq_addr, RST_PC);

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            rcyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
